// File: rtl/melody_pkg.sv
// Shared types and constants for the alarm melody player: FSM states,
// note ROM layout, melody contents and the pitch half-period table.
package melody_pkg;

   localparam int unsigned PITCH_W    = 4;
   localparam int unsigned NOTE_DUR_W = 2;
   localparam int unsigned NOTE_W     = PITCH_W + NOTE_DUR_W;
   localparam int unsigned NOTES      = 8;
   localparam int unsigned IDX_W      = 3;
   localparam int unsigned HALF_W     = 17;
   localparam int unsigned PASS_W     = 4;

   typedef enum logic [1:0] {IDLE, TONE, REST, DONE} state_t;

   typedef struct packed {
      logic [PITCH_W-1:0]    pitch;
      logic [NOTE_DUR_W-1:0] dur;
   } note_t;

   // C5..B5 half periods in 50 MHz cycles
   localparam logic [HALF_W-1:0] PITCH_HALF [1:12] = '{
      17'd47778, 17'd45097, 17'd42566, 17'd40177, 17'd37922, 17'd35793,
      17'd33784, 17'd31888, 17'd30098, 17'd28409, 17'd26815, 17'd25310
   };

   // pitch 0 is a rest; dur is length in beats minus one
   localparam note_t MELODY [0:NOTES-1] = '{
      '{4'd1, 2'd0}, '{4'd3, 2'd0}, '{4'd5, 2'd3}, '{4'd8, 2'd2},
      '{4'd0, 2'd0}, '{4'd8, 2'd0}, '{4'd5, 2'd0}, '{4'd1, 2'd3}
   };

   // Scaled half period; never returns 0 so the tone counter reload stays sane
   function automatic logic [HALF_W-1:0] half_period(input logic [PITCH_W-1:0] pitch,
                                                     input int unsigned shift);
      logic [HALF_W-1:0] h;
      h = HALF_W'(1);
      if (pitch >= PITCH_W'(1) && pitch <= PITCH_W'(12))
         h = PITCH_HALF[pitch] >> shift;
      if (h == '0)
         h = HALF_W'(1);
      return h;
   endfunction

endpackage

// File: rtl/alarm_melody_tone_gen.sv
// Square-wave generator: half-period down-counter that toggles the buzzer,
// cleared to silence on load or whenever it is not running.
module tone_gen
   import melody_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              run,
   input  logic [HALF_W-1:0] half,
   output logic              buzzer
);

   logic [HALF_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         buzzer <= 1'b0;
      end else if (load) begin
         cnt    <= half - HALF_W'(1);
         buzzer <= 1'b0;
      end else if (run) begin
         if (cnt == '0) begin
            cnt    <= half - HALF_W'(1);
            buzzer <= ~buzzer;
         end else begin
            cnt <= cnt - HALF_W'(1);
         end
      end else begin
         buzzer <= 1'b0;
      end
   end

endmodule

// File: rtl/alarm_melody.sv
// Alarm melody player: plays the note ROM on a ring rising edge, looping up
// to REPEATS passes, cancelled by stop or by ring falling.
module alarm_melody
   import melody_pkg::*;
#(
   parameter int unsigned BEAT_CYC    = 12_500_000,
   parameter int unsigned GAP_CYC     = 1_250_000,
   parameter int unsigned REPEATS     = 4,
   parameter int unsigned SCALE_SHIFT = 0
) (
   input  logic             clk_50Mhz,
   input  logic             rst,
   input  logic             ring,
   input  logic             stop,
   output logic             buzzer,
   output logic             playing,
   output logic [IDX_W-1:0] note_idx
);

   localparam int unsigned DUR_CNT_W = (4 * BEAT_CYC > 1) ? $clog2(4 * BEAT_CYC) : 1;
   localparam int unsigned GAP_CNT_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYC - 1);

   state_t                 state;
   logic                   ring_d;
   logic [PASS_W-1:0]      pass;
   logic [DUR_CNT_W-1:0]   dur_cnt;
   logic [GAP_CNT_W-1:0]   gap_cnt;

   logic                   start_c, abort_c, last_note_c, more_pass_c;
   logic                   gap_end_c, load_c, run_c;
   logic [IDX_W-1:0]       next_idx_c, sel_idx_c;
   logic [PITCH_W-1:0]     cur_pitch_c;
   note_t                  sel_note_c;
   logic [HALF_W-1:0]      half_c;

   function automatic logic [DUR_CNT_W-1:0] dur_load(input note_t n);
      return DUR_CNT_W'((32'(n.dur) + 32'd1) * BEAT_CYC - 32'd1);
   endfunction

   // sel_note is the note the tone generator plays after this edge
   always_comb begin
      start_c     = ring & ~ring_d;
      abort_c     = stop | ~ring;
      last_note_c = (note_idx == IDX_W'(NOTES - 1));
      more_pass_c = (pass < PASS_W'(REPEATS));
      gap_end_c   = (state == REST) && !abort_c && (gap_cnt == '0);
      next_idx_c  = last_note_c ? '0 : note_idx + IDX_W'(1);
      load_c      = ((state == IDLE) && start_c) ||
                    (gap_end_c && (!last_note_c || more_pass_c));
      sel_idx_c   = (state == IDLE) ? '0 : (load_c ? next_idx_c : note_idx);
      sel_note_c  = MELODY[sel_idx_c];
      cur_pitch_c = MELODY[note_idx].pitch;
      half_c      = half_period(sel_note_c.pitch, SCALE_SHIFT);
      run_c       = (state == TONE) && !abort_c && (dur_cnt != '0) &&
                    (cur_pitch_c != '0);
   end

   always_ff @(posedge clk_50Mhz) begin
      if (rst) begin
         state    <= IDLE;
         ring_d   <= 1'b0;
         pass     <= '0;
         dur_cnt  <= '0;
         gap_cnt  <= '0;
         playing  <= 1'b0;
         note_idx <= '0;
      end else begin
         ring_d <= ring;
         case (state)
            IDLE: begin
               if (start_c) begin
                  state    <= TONE;
                  note_idx <= '0;
                  pass     <= PASS_W'(1);
                  dur_cnt  <= dur_load(sel_note_c);
                  playing  <= 1'b1;
               end
            end
            TONE: begin
               if (abort_c) begin
                  state   <= DONE;
                  playing <= 1'b0;
               end else if (dur_cnt == '0) begin
                  state   <= REST;
                  gap_cnt <= GAP_LOAD;
               end else begin
                  dur_cnt <= dur_cnt - DUR_CNT_W'(1);
               end
            end
            REST: begin
               if (abort_c) begin
                  state   <= DONE;
                  playing <= 1'b0;
               end else if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - GAP_CNT_W'(1);
               end else if (load_c) begin
                  state    <= TONE;
                  note_idx <= next_idx_c;
                  dur_cnt  <= dur_load(sel_note_c);
                  if (last_note_c)
                     pass <= pass + PASS_W'(1);
               end else begin
                  state   <= DONE;
                  playing <= 1'b0;
               end
            end
            DONE: begin
               // held here while ring stays high so it cannot retrigger
               if (!ring)
                  state <= IDLE;
            end
         endcase
      end
   end

   tone_gen u_tone (
      .clk    (clk_50Mhz),
      .rst    (rst),
      .load   (load_c),
      .run    (run_c),
      .half   (half_c),
      .buzzer (buzzer)
   );

endmodule

// File: tb/tb_alarm_melody.sv
// Randomized self-checking bench for alarm_melody against a timeline model
// derived from the melody table, beat length, gap length and pass count.
module tb_alarm_melody;

   localparam int BEAT  = 64;
   localparam int GAP   = 8;
   localparam int SHIFT = 8;
   localparam int REPS  = 2;

   localparam int MEL_PITCH [8] = '{1, 3, 5, 8, 0, 8, 5, 1};
   localparam int MEL_DUR   [8] = '{0, 0, 3, 2, 0, 0, 0, 3};
   localparam int HALF_FULL [13] = '{0, 47778, 45097, 42566, 40177, 37922, 35793,
                                     33784, 31888, 30098, 28409, 26815, 25310};

   logic       clk = 1'b0;
   logic       rst, ring, stop;
   logic       buzzer, playing;
   logic [2:0] note_idx;

   int n_checks = 0;
   int n_pass   = 0;

   alarm_melody #(
      .BEAT_CYC(BEAT), .GAP_CYC(GAP), .REPEATS(REPS), .SCALE_SHIFT(SHIFT)
   ) dut (
      .clk_50Mhz (clk),
      .rst       (rst),
      .ring      (ring),
      .stop      (stop),
      .buzzer    (buzzer),
      .playing   (playing),
      .note_idx  (note_idx)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int note_len(input int n);
      return (MEL_DUR[n] + 1) * BEAT;
   endfunction

   function automatic int note_start(input int n);
      int s = 0;
      for (int i = 0; i < n; i++) s += note_len(i) + GAP;
      return s;
   endfunction

   function automatic int total_len();
      return REPS * note_start(8);
   endfunction

   // Expected {playing, buzzer, note_idx} k cycles after the start edge
   function automatic logic [4:0] model(input int k);
      int t = k;
      for (int p = 0; p < REPS; p++) begin
         for (int n = 0; n < 8; n++) begin
            int len = note_len(n);
            if (t < len) begin
               logic bz = 1'b0;
               if (MEL_PITCH[n] != 0) begin
                  int half = HALF_FULL[MEL_PITCH[n]] >> SHIFT;
                  bz = ((t / half) % 2) == 1;
               end
               return {1'b1, bz, 3'(n)};
            end
            t -= len;
            if (t < GAP) return {1'b1, 1'b0, 3'(n)};
            t -= GAP;
         end
      end
      return 5'b0;
   endfunction

   task automatic test_reset();
      rst = 1'b1; ring = 1'b0; stop = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({buzzer, playing, note_idx} !== 5'b0)
         $display("FAIL reset: got bz=%b pl=%b idx=%0d, want 0 0 0", buzzer, playing, note_idx);
      else n_pass++;
      rst = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         n_checks++;
         if ({buzzer, playing, note_idx} !== 5'b0)
            $display("FAIL idle_quiet c=%0d: got bz=%b pl=%b idx=%0d, want 0 0 0",
                     i, buzzer, playing, note_idx);
         else n_pass++;
      end
   endtask

   // Drop ring and let the player settle back to idle, checking it is silent
   task automatic release_ring(input string name);
      ring = 1'b0;
      repeat (2 + $urandom_range(0, 3)) begin
         tick();
         n_checks++;
         if (playing !== 1'b0 || buzzer !== 1'b0)
            $display("FAIL %s_release: got pl=%b bz=%b, want 0 0", name, playing, buzzer);
         else n_pass++;
      end
   endtask

   task automatic test_full_melody();
      logic [4:0] want;
      int extra = $urandom_range(20, 200);
      ring = 1'b1;
      for (int k = 0; k < total_len() + extra; k++) begin
         tick();
         want = model(k);
         n_checks++;
         if (playing !== want[4] || buzzer !== want[3] || (want[4] && note_idx !== want[2:0]))
            $display("FAIL full k=%0d: got pl=%b bz=%b idx=%0d, want pl=%b bz=%b idx=%0d",
                     k, playing, buzzer, note_idx, want[4], want[3], want[2:0]);
         else n_pass++;
      end
      release_ring("full");
      ring = 1'b1;
      for (int k = 0; k < 300; k++) begin
         tick();
         want = model(k);
         n_checks++;
         if (playing !== want[4] || buzzer !== want[3] || (want[4] && note_idx !== want[2:0]))
            $display("FAIL retrigger k=%0d: got pl=%b bz=%b idx=%0d, want pl=%b bz=%b idx=%0d",
                     k, playing, buzzer, note_idx, want[4], want[3], want[2:0]);
         else n_pass++;
      end
      release_ring("retrigger");
   endtask

   task automatic test_stop();
      logic [4:0] want;
      int kstop = note_start(3) + $urandom_range(0, note_len(3) - 1);
      ring = 1'b1;
      for (int k = 0; k <= kstop; k++) begin
         tick();
         want = model(k);
         n_checks++;
         if (playing !== want[4] || buzzer !== want[3] || (want[4] && note_idx !== want[2:0]))
            $display("FAIL stop_pre k=%0d: got pl=%b bz=%b idx=%0d, want pl=%b bz=%b idx=%0d",
                     k, playing, buzzer, note_idx, want[4], want[3], want[2:0]);
         else n_pass++;
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      repeat ($urandom_range(50, 300)) begin
         n_checks++;
         if (playing !== 1'b0 || buzzer !== 1'b0)
            $display("FAIL stop_hold: got pl=%b bz=%b, want 0 0", playing, buzzer);
         else n_pass++;
         ring = 1'b1;
         tick();
      end
      release_ring("stop");
   endtask

   task automatic test_ring_fall();
      logic [4:0] want;
      int n     = $urandom_range(0, 7);
      int kfall = note_start(n) + note_len(n) + $urandom_range(0, GAP - 1);
      ring = 1'b1;
      for (int k = 0; k <= kfall; k++) begin
         tick();
         want = model(k);
         n_checks++;
         if (playing !== want[4] || buzzer !== want[3] || (want[4] && note_idx !== want[2:0]))
            $display("FAIL fall_pre k=%0d: got pl=%b bz=%b idx=%0d, want pl=%b bz=%b idx=%0d",
                     k, playing, buzzer, note_idx, want[4], want[3], want[2:0]);
         else n_pass++;
      end
      release_ring("fall");
      ring = 1'b1;
      for (int k = 0; k < total_len() + 5; k++) begin
         tick();
         want = model(k);
         n_checks++;
         if (playing !== want[4] || buzzer !== want[3] || (want[4] && note_idx !== want[2:0]))
            $display("FAIL fall_restart k=%0d: got pl=%b bz=%b idx=%0d, want pl=%b bz=%b idx=%0d",
                     k, playing, buzzer, note_idx, want[4], want[3], want[2:0]);
         else n_pass++;
      end
      release_ring("fall_restart");
   endtask

   task automatic test_rst_mid();
      logic [4:0] want;
      int kr = note_start(2) + $urandom_range(0, note_len(2) - 1);
      ring = 1'b1;
      for (int k = 0; k <= kr; k++) begin
         tick();
         want = model(k);
         n_checks++;
         if (playing !== want[4] || buzzer !== want[3] || (want[4] && note_idx !== want[2:0]))
            $display("FAIL rst_pre k=%0d: got pl=%b bz=%b idx=%0d, want pl=%b bz=%b idx=%0d",
                     k, playing, buzzer, note_idx, want[4], want[3], want[2:0]);
         else n_pass++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({buzzer, playing, note_idx} !== 5'b0)
         $display("FAIL rst_mid: got bz=%b pl=%b idx=%0d, want 0 0 0", buzzer, playing, note_idx);
      else n_pass++;
      // ring still high and its history was cleared, so play restarts
      for (int k = 0; k < total_len() + 5; k++) begin
         tick();
         want = model(k);
         n_checks++;
         if (playing !== want[4] || buzzer !== want[3] || (want[4] && note_idx !== want[2:0]))
            $display("FAIL rst_restart k=%0d: got pl=%b bz=%b idx=%0d, want pl=%b bz=%b idx=%0d",
                     k, playing, buzzer, note_idx, want[4], want[3], want[2:0]);
         else n_pass++;
      end
      release_ring("rst");
   endtask

   task automatic test_stop_idle();
      logic [4:0] want;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      repeat (10) begin
         tick();
         n_checks++;
         if (playing !== 1'b0 || buzzer !== 1'b0)
            $display("FAIL stop_idle: got pl=%b bz=%b, want 0 0", playing, buzzer);
         else n_pass++;
      end
      ring = 1'b1;
      stop = 1'b1;
      for (int k = 0; k < 200; k++) begin
         tick();
         stop = 1'b0;
         want = model(k);
         n_checks++;
         if (playing !== want[4] || buzzer !== want[3] || (want[4] && note_idx !== want[2:0]))
            $display("FAIL start_vs_stop k=%0d: got pl=%b bz=%b idx=%0d, want pl=%b bz=%b idx=%0d",
                     k, playing, buzzer, note_idx, want[4], want[3], want[2:0]);
         else n_pass++;
      end
      release_ring("stop_idle");
   endtask

   initial begin
      test_reset();
      test_full_melody();
      test_stop();
      test_ring_fall();
      test_rst_mid();
      test_stop_idle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
